// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-2 message scheduler shared constants and state type
package sha2_pkg;

  localparam int WIN = 16;

  localparam int S256_S0_ROT1 = 7;
  localparam int S256_S0_ROT2 = 18;
  localparam int S256_S0_SHR  = 3;
  localparam int S256_S1_ROT1 = 17;
  localparam int S256_S1_ROT2 = 19;
  localparam int S256_S1_SHR  = 10;

  localparam int S512_S0_ROT1 = 1;
  localparam int S512_S0_ROT2 = 8;
  localparam int S512_S0_SHR  = 7;
  localparam int S512_S1_ROT1 = 19;
  localparam int S512_S1_ROT2 = 61;
  localparam int S512_S1_SHR  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PASS,
    ST_CALC,
    ST_PRESENT,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/sha2_sched_sigma.sv
// rtl/sha2_sched_sigma.sv - combinational small-sigma functions for SHA-256/SHA-512
module sha2_sched_sigma
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] i_x15,
  input  logic [WORD_W-1:0] i_x2,
  output logic [WORD_W-1:0] o_sigma0,
  output logic [WORD_W-1:0] o_sigma1
);

  localparam int S0_R1 = (WORD_W == 64) ? S512_S0_ROT1 : S256_S0_ROT1;
  localparam int S0_R2 = (WORD_W == 64) ? S512_S0_ROT2 : S256_S0_ROT2;
  localparam int S0_SH = (WORD_W == 64) ? S512_S0_SHR  : S256_S0_SHR;
  localparam int S1_R1 = (WORD_W == 64) ? S512_S1_ROT1 : S256_S1_ROT1;
  localparam int S1_R2 = (WORD_W == 64) ? S512_S1_ROT2 : S256_S1_ROT2;
  localparam int S1_SH = (WORD_W == 64) ? S512_S1_SHR  : S256_S1_SHR;

  // Rotations are plain bit re-wiring; only the XORs cost logic.
  assign o_sigma0 = {i_x15[S0_R1-1:0], i_x15[WORD_W-1:S0_R1]}
                  ^ {i_x15[S0_R2-1:0], i_x15[WORD_W-1:S0_R2]}
                  ^ (i_x15 >> S0_SH);

  assign o_sigma1 = {i_x2[S1_R1-1:0], i_x2[WORD_W-1:S1_R1]}
                  ^ {i_x2[S1_R2-1:0], i_x2[WORD_W-1:S1_R2]}
                  ^ (i_x2 >> S1_SH);

endmodule

// File: rtl/sha2_msg_scheduler.sv
// rtl/sha2_msg_scheduler.sv - SHA-2 message schedule generator over a 16-word ring
module sha2_msg_scheduler
  import sha2_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int ROUNDS       = 64,
  parameter int SINGLE_CYCLE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [WORD_W-1:0] m_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [6:0]        w_round,
  output logic              busy,
  output logic              done
);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("sha2_msg_scheduler: WORD_W must be 32 or 64");
  end

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  sched_state_t      r_state, w_next_state;
  logic [3:0]        r_cnt;
  logic [6:0]        r_t;
  logic [1:0]        r_phase;
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] r_mem [WIN];

  logic [3:0]        w_idx_cur, w_idx_m15, w_idx_m7, w_idx_m2;
  logic [WORD_W-1:0] w_s0, w_s1, w_add_a, w_add_b, w_acc_next;
  logic              w_calc_last;

  // W[t-16] lives where W[t] will be written; the others are fixed ring offsets.
  assign w_idx_cur = r_t[3:0];
  assign w_idx_m15 = r_t[3:0] + 4'd1;
  assign w_idx_m7  = r_t[3:0] + 4'd9;
  assign w_idx_m2  = r_t[3:0] + 4'd14;

  sha2_sched_sigma #(
    .WORD_W(WORD_W)
  ) u_sigma (
    .i_x15   (r_mem[w_idx_m15]),
    .i_x2    (r_mem[w_idx_m2]),
    .o_sigma0(w_s0),
    .o_sigma1(w_s1)
  );

  assign w_calc_last = (SINGLE_CYCLE != 0) || (r_phase == 2'd2);
  assign w_round     = r_t;

  always_comb begin
    w_add_a = r_acc;
    w_add_b = '0;
    case (r_phase)
      2'd0: begin
        w_add_a = r_mem[w_idx_cur];
        w_add_b = w_s0;
      end
      2'd1:    w_add_b = r_mem[w_idx_m7];
      default: w_add_b = w_s1;
    endcase
    if (SINGLE_CYCLE != 0) begin
      w_acc_next = r_mem[w_idx_cur] + w_s0 + r_mem[w_idx_m7] + w_s1;
    end else begin
      w_acc_next = w_add_a + w_add_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    m_ready      = 1'b0;
    w_valid      = 1'b0;
    w_data       = '0;
    busy         = (r_state != ST_IDLE);
    done         = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_LOAD: begin
        m_ready = 1'b1;
        if (m_valid && r_cnt == 4'd15) w_next_state = ST_PASS;
      end
      ST_PASS: begin
        w_valid = 1'b1;
        w_data  = r_mem[w_idx_cur];
        if (w_ready && r_t == 7'd15) w_next_state = ST_CALC;
      end
      ST_CALC: begin
        if (w_calc_last) w_next_state = ST_PRESENT;
      end
      ST_PRESENT: begin
        w_valid = 1'b1;
        w_data  = r_acc;
        if (w_ready) w_next_state = (r_t == LAST_T) ? ST_DONE : ST_CALC;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // A restart wins over everything, voiding any handshake in the same cycle.
    if (start) w_next_state = ST_LOAD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_t     <= '0;
      r_phase <= '0;
      r_acc   <= '0;
    end else if (start) begin
      r_cnt   <= '0;
      r_t     <= '0;
      r_phase <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_LOAD:             if (m_valid) r_cnt <= r_cnt + 4'd1;
        ST_PASS, ST_PRESENT: if (w_ready) r_t <= r_t + 7'd1;
        ST_CALC: begin
          r_acc   <= w_acc_next;
          r_phase <= w_calc_last ? 2'd0 : r_phase + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!start) begin
      if (r_state == ST_LOAD && m_valid) begin
        r_mem[r_cnt] <= m_data;
      end else if (r_state == ST_PRESENT && w_ready) begin
        r_mem[w_idx_cur] <= r_acc;
      end
    end
  end

endmodule

// File: doc/sha2_msg_scheduler.md
SHA2_MSG_SCHEDULER -- requirements
Module: sha2_msg_scheduler

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning word width (32 = SHA-256, 64 = SHA-512); other values are illegal and SHALL fail elaboration.
REQ-002 SHALL have parameter ROUNDS, default 64, meaning rounds per block (64 when WORD_W=32, 80 when WORD_W=64).
REQ-003 SHALL have parameter SINGLE_CYCLE, default 0, meaning 0 = one shared adder with 4 cycles per computed word, 1 = four-input add with 1 cycle per word.
REQ-004 SHALL have port clk, input, 1, meaning clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, meaning a 1-cycle pulse that begins a new block.
REQ-007 SHALL have ports m_valid (input, 1), m_ready (output, 1) and m_data (input, WORD_W), meaning the message-word load handshake.
REQ-008 SHALL have ports w_valid (output, 1), w_ready (input, 1) and w_data (output, WORD_W), meaning the W[t] output handshake.
REQ-009 SHALL have port w_round, output, 7, meaning the index t of w_data.
REQ-010 SHALL have ports busy (output, 1) and done (output, 1), meaning not IDLE, and a 1-cycle pulse after the final W handshake.

Function
REQ-011 SHALL implement states IDLE, LOAD, PASS (t<16), CALC (t>=16, computing), PRESENT (t>=16, w_valid high) and DONE.
REQ-012 SHALL go IDLE->LOAD on start, clearing the load counter and t.
REQ-013 LOAD SHALL drive m_ready=1; each cycle with m_valid&m_ready SHALL write m_data to mem[cnt] and increment cnt; the 16th accept SHALL go to PASS with t=0.
REQ-014 PASS SHALL drive w_valid=1, w_data=mem[t], w_round=t; each handshake SHALL increment t; the handshake at t=15 SHALL go to CALC.
REQ-015 W[t] for t>=16 SHALL equal sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^WORD_W.
REQ-016 Ring addressing SHALL use t mod 16 for W[t-16], (t-15), (t-7) and (t-2) mod 16.
REQ-017 With SINGLE_CYCLE=0, CALC SHALL last 3 cycles (acc=W[t-16]+s0; acc+=W[t-7]; acc+=s1), then go to PRESENT with w_data=acc.
REQ-018 With SINGLE_CYCLE=1, CALC SHALL last 1 cycle, registering the full sum, then go to PRESENT.
REQ-019 On a PRESENT handshake, W[t] SHALL be written to mem[t mod 16] and t incremented; if t=ROUNDS-1 the next state SHALL be DONE, otherwise CALC.
REQ-020 While w_valid=1 and w_ready=0, w_data and w_round SHALL hold stable and no state SHALL advance.
REQ-021 Throughput with w_ready held high SHALL be 1 word/cycle in PASS and 4 cycles/word (SINGLE_CYCLE=0) or 2 cycles/word (SINGLE_CYCLE=1) for t>=16.
REQ-022 DONE SHALL assert done for 1 cycle, then go to IDLE.
REQ-023 A start pulse in any non-IDLE state SHALL abort the block and enter LOAD with cleared counters; any output handshake in that same cycle SHALL be void.
REQ-024 m_valid outside LOAD SHALL be ignored; w_ready outside PASS/PRESENT SHALL be ignored.
REQ-025 t SHALL never wrap; the final round SHALL be ROUNDS-1.

Reset
REQ-026 Reset SHALL force IDLE, m_ready=0, w_valid=0, w_data=0, w_round=0, busy=0, done=0, acc=0 and counters=0.
REQ-027 Reset mid-operation SHALL abandon the block; mem contents are don't-care and are not reset.

Structure
REQ-028 Package sha2_pkg SHALL hold the sigma rotate/shift constants for both widths, the state enum and a localparam for the 16-word window.
REQ-029 Sub-module sha2_sched_sigma (parameter WORD_W) SHALL compute sigma0 and sigma1 combinationally; the adder and ring SHALL stay in the top module.

Verification
REQ-030 WORD_W=32, "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) -> W16=0x61626380, W17=0x000F0000, and done after W63.
REQ-031 WORD_W=64, ROUNDS=80, W0=0x6162638000000000, W15=0x18 -> W16=0x6162638000000000, and done after w_round=79.
REQ-032 w_ready held high, SINGLE_CYCLE=0 -> 16 + 48*4 cycles from first PASS to the last handshake; SINGLE_CYCLE=1 -> 16 + 48*2.
REQ-033 w_ready low for 5 cycles at t=20 -> w_data and w_round=20 stable throughout; the sequence matches the golden model.
REQ-034 start at t=30 -> m_ready=1 next cycle, a new block loads, and the output matches the golden model from t=0.
REQ-035 reset_n low at t=40 -> all outputs 0 asynchronously; after release, a full block completes correctly.
